dmem_arbiter: RTL

//  Shares the single-port data RAM (1-cycle registered read) between the pipeline LSU and an external

---
 rtl/dmem_arbiter_pkg.sv | 42 ++++
 rtl/dmem_arbiter_reg.sv | 23 ++
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Purpose : shared types for the data-RAM arbiter (request bundle, read owner, arbitration state).
// Latency : n/a (types only).
// Backpressure: n/a.
package dmem_arbiter_pkg;

    // Request bundles carry the byte address at this fixed width.
    // Narrower ADDR_W values are zero-extended into it.
    localparam int DMEM_ADDR_MAX_W = 16;

    typedef struct packed {
        logic                       we;
        logic [DMEM_ADDR_MAX_W-1:0] addr;
        logic [3:0]                 be;
        logic [31:0]                wdata;
    } dmem_req_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LSU  = 2'd1,
        OWN_EXT  = 2'd2
    } dmem_owner_e;

    typedef enum logic {
        ARB_LSU_PRIO   = 1'b0,
        ARB_EXT_FORCED = 1'b1
    } arb_state_e;

    function automatic dmem_req_t pack_req(
        input logic                       we,
        input logic [DMEM_ADDR_MAX_W-1:0] addr,
        input logic [3:0]                 be,
        input logic [31:0]                wdata
    );
        dmem_req_t r;
        r.we    = we;
        r.addr  = addr;
        r.be    = be;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/dmem_arbiter_reg.sv
// Purpose : plain W-bit register with synchronous active-high reset to RST_VAL.
// Latency : 1 cycle (d_i visible on q_o after the next rising edge).
// Backpressure: none; loads every cycle.
// Ports   : clk_i clock, rst_i sync reset, d_i next value, q_o registered value.
module dmem_arbiter_reg #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= RST_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose : shares the single-port data RAM between the LSU (priority) and an external port,
//           with a starvation guard that forces one EXT grant after MAX_WAIT denied cycles.
// Latency : grant and RAM drive are combinational; load data returns exactly 1 cycle after grant.
// Backpressure: the losing LSU request is stalled via o_lsu_stall; the losing EXT request waits.
// Ports   : i_clk/i_rst clock and sync reset; i_lsu_* / i_ext_* request ports; o_*_gnt grants;
//           o_*_rvalid/o_*_rdata load returns; o_ram_* RAM drive; i_ram_q RAM read data.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lsu_req,
    input  logic              i_lsu_we,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic [3:0]        i_lsu_be,
    input  logic [31:0]       i_lsu_wdata,
    output logic              o_lsu_gnt,
    output logic              o_lsu_stall,
    output logic              o_lsu_rvalid,
    output logic [31:0]       o_lsu_rdata,
    input  logic              i_ext_req,
    input  logic              i_ext_we,
    input  logic [ADDR_W-1:0] i_ext_addr,
    input  logic [3:0]        i_ext_be,
    input  logic [31:0]       i_ext_wdata,
    output logic              o_ext_gnt,
    output logic              o_ext_rvalid,
    output logic [31:0]       o_ext_rdata,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [3:0]        o_ram_byteena,
    output logic [31:0]       o_ram_data,
    output logic              o_ram_wren,
    input  logic [31:0]       i_ram_q
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    dmem_req_t        lsu_req, ext_req, sel_req;
    logic             lsu_gnt, ext_gnt;

    logic             state_raw;
    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W:0]   wait_inc;
    logic             starve;
    logic [1:0]       rd_owner_raw;
    dmem_owner_e      rd_owner_q, rd_owner_d;
    logic [31:0]      lsu_rdata_q, lsu_rdata_d;
    logic [31:0]      ext_rdata_q, ext_rdata_d;
    logic             lsu_rvalid, ext_rvalid;

    assign state_q    = arb_state_e'(state_raw);
    assign rd_owner_q = dmem_owner_e'(rd_owner_raw);

    assign lsu_req = pack_req(i_lsu_we, DMEM_ADDR_MAX_W'(i_lsu_addr), i_lsu_be, i_lsu_wdata);
    assign ext_req = pack_req(i_ext_we, DMEM_ADDR_MAX_W'(i_ext_addr), i_ext_be, i_ext_wdata);

    // Grant: nothing is granted while reset is held, so every output reads 0 in reset.
    always_comb begin
        lsu_gnt = 1'b0;
        ext_gnt = 1'b0;
        if (!i_rst) begin
            if (state_q == ARB_EXT_FORCED && i_ext_req) begin
                ext_gnt = 1'b1;
            end else if (i_lsu_req) begin
                lsu_gnt = 1'b1;
            end else if (i_ext_req) begin
                ext_gnt = 1'b1;
            end
        end
    end

    // Starvation counter: counts consecutive denied EXT cycles; the cycle whose increment
    // reaches MAX_WAIT schedules one forced EXT cycle.
    always_comb begin
        wait_inc   = {1'b0, wait_cnt_q} + (CNT_W+1)'(1);
        starve     = (wait_inc >= (CNT_W+1)'(MAX_WAIT));
        wait_cnt_d = '0;
        state_d    = ARB_LSU_PRIO;
        if (i_ext_req && !ext_gnt) begin
            wait_cnt_d = starve ? CNT_W'(MAX_WAIT) : wait_inc[CNT_W-1:0];
            if (state_q == ARB_LSU_PRIO && starve) begin
                state_d = ARB_EXT_FORCED;
            end
        end
    end

    // RAM drive from the granted port; idle drives all zeros.
    always_comb begin
        sel_req = '0;
        if (lsu_gnt) begin
            sel_req = lsu_req;
        end else if (ext_gnt) begin
            sel_req = ext_req;
        end
    end

    assign o_ram_addr    = {2'b00, sel_req.addr[ADDR_W-1:2]};
    assign o_ram_byteena = sel_req.be;
    assign o_ram_data    = sel_req.wdata;
    assign o_ram_wren    = (lsu_gnt | ext_gnt) & sel_req.we;

    // Read return: remember who issued the load; RAM data arrives next cycle.
    always_comb begin
        rd_owner_d = OWN_NONE;
        if (lsu_gnt && !i_lsu_we) begin
            rd_owner_d = OWN_LSU;
        end else if (ext_gnt && !i_ext_we) begin
            rd_owner_d = OWN_EXT;
        end
    end

    // A load return pending across a reset assertion is dropped.
    assign lsu_rvalid  = (rd_owner_q == OWN_LSU) && !i_rst;
    assign ext_rvalid  = (rd_owner_q == OWN_EXT) && !i_rst;
    assign lsu_rdata_d = lsu_rvalid ? i_ram_q : lsu_rdata_q;
    assign ext_rdata_d = ext_rvalid ? i_ram_q : ext_rdata_q;

    assign o_lsu_gnt    = lsu_gnt;
    assign o_ext_gnt    = ext_gnt;
    assign o_lsu_stall  = i_lsu_req & ~lsu_gnt & ~i_rst;
    assign o_lsu_rvalid = lsu_rvalid;
    assign o_ext_rvalid = ext_rvalid;
    assign o_lsu_rdata  = i_rst ? 32'd0 : lsu_rdata_d;
    assign o_ext_rdata  = i_rst ? 32'd0 : ext_rdata_d;

    dmem_arbiter_reg #(.W(1)) u_state_reg (
        .clk_i(i_clk), .rst_i(i_rst), .d_i(state_d), .q_o(state_raw)
    );

    dmem_arbiter_reg #(.W(CNT_W)) u_wait_reg (
        .clk_i(i_clk), .rst_i(i_rst), .d_i(wait_cnt_d), .q_o(wait_cnt_q)
    );

    dmem_arbiter_reg #(.W(2)) u_owner_reg (
        .clk_i(i_clk), .rst_i(i_rst), .d_i(rd_owner_d), .q_o(rd_owner_raw)
    );

    dmem_arbiter_reg #(.W(32)) u_lsu_rdata_reg (
        .clk_i(i_clk), .rst_i(i_rst), .d_i(lsu_rdata_d), .q_o(lsu_rdata_q)
    );

    dmem_arbiter_reg #(.W(32)) u_ext_rdata_reg (
        .clk_i(i_clk), .rst_i(i_rst), .d_i(ext_rdata_d), .q_o(ext_rdata_q)
    );

endmodule
